// File: rtl/fir_decim_output_stage.sv
// fir_decim_output_stage: decimate, round/saturate and FWFT-buffer the FIR output stream
module fir_decim_output_stage #(
  parameter int INPUT_WIDTH  = 26,
  parameter int OUTPUT_WIDTH = 16,
  parameter int DECIM_FACTOR = 4,
  parameter int DECIM_PHASE  = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             valid_in,
  input  logic signed [INPUT_WIDTH-1:0]    din,
  input  logic                             sync,
  input  logic                             ready_out,
  output logic                             valid_out,
  output logic [OUTPUT_WIDTH-1:0]          dout,
  output logic                             sat_pulse,
  output logic                             overflow,
  input  logic                             overflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);
  localparam int CW = DECIM_FACTOR > 1 ? $clog2(DECIM_FACTOR) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int D  = INPUT_WIDTH - OUTPUT_WIDTH;
  logic [CW-1:0] cnt, eff, cnt_nxt;
  logic keep, sat;
  logic [OUTPUT_WIDTH-1:0] rnd;
  always_comb begin
    eff     = sync ? '0 : cnt;
    keep    = valid_in && (eff == CW'(DECIM_PHASE));
    cnt_nxt = valid_in ? ((eff == CW'(DECIM_FACTOR - 1)) ? '0 : eff + 1'b1) : eff;
  end
  generate
    if (D > 0) begin : g_rnd
      localparam logic signed [INPUT_WIDTH:0] HALF = (INPUT_WIDTH+1)'(1) << (D - 1);
      localparam logic signed [INPUT_WIDTH:0] MAXV = (INPUT_WIDTH+1)'((1 << (OUTPUT_WIDTH - 1)) - 1);
      localparam logic signed [INPUT_WIDTH:0] MINV = ~MAXV;
      logic signed [INPUT_WIDTH:0] t;
      assign t   = ($signed({din[INPUT_WIDTH-1], din}) + HALF) >>> D;
      assign sat = (t > MAXV) || (t < MINV);
      assign rnd = (t > MAXV) ? {1'b0, {(OUTPUT_WIDTH-1){1'b1}}} :
                   (t < MINV) ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}} : t[OUTPUT_WIDTH-1:0];
    end else begin : g_ext
      assign sat = 1'b0;
      assign rnd = OUTPUT_WIDTH'(din);
    end
  endgenerate
  logic stg_v;
  logic [OUTPUT_WIDTH-1:0] stg_d, hold;
  logic [OUTPUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic full, pop, push, drop;
  always_comb begin
    full = fifo_level == (AW+1)'(FIFO_DEPTH);
    pop  = valid_out && ready_out;
    push = stg_v && (!full || pop);
    drop = stg_v && full && !pop;
  end
  assign valid_out = fifo_level != '0;
  assign dout      = valid_out ? mem[rp] : hold;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      stg_v      <= 1'b0;
      stg_d      <= '0;
      sat_pulse  <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      hold       <= '0;
    end else begin
      cnt        <= cnt_nxt;
      stg_v      <= keep;
      stg_d      <= keep ? rnd : stg_d;
      sat_pulse  <= keep && sat;
      wp         <= push ? wp + 1'b1 : wp;
      rp         <= pop ? rp + 1'b1 : rp;
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
      overflow   <= drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow);
      hold       <= pop ? mem[rp] : hold;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= stg_d;
  end
endmodule
